// File: rtl/vg_pkg.sv
// Shared definitions for the vector-generator strobe controller.
package vg_pkg;

  localparam int VG_DIV_DEF     = 4;
  localparam int VG_WAIT_W_DEF  = 4;
  localparam int VG_STALL_W_DEF = 16;

  // Controller states. The encoding is fixed so debug readback stays stable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } vg_state_e;

endpackage

// File: rtl/vg_phase_div.sv
// Phase counter 0..DIV-1 with clear, hold and wrap; flags the last phase.
module vg_phase_div #(
  parameter int DIV  = 4,
  parameter int PH_W = $clog2(DIV)
) (
  input  logic            clk_12MHz,
  input  logic            reset_not,
  input  logic            i_clr,
  input  logic            i_hold,
  output logic [PH_W-1:0] o_phase,
  output logic            o_at_end
);

  localparam logic [PH_W-1:0] PH_END = PH_W'(DIV - 1);

  logic [PH_W-1:0] r_phase;

  // Clear wins over hold; otherwise count up and wrap at the last phase.
  always_ff @(posedge clk_12MHz or negedge reset_not) begin
    if (!reset_not)          r_phase <= '0;
    else if (i_clr)          r_phase <= '0;
    else if (i_hold)         r_phase <= r_phase;
    else if (r_phase == PH_END) r_phase <= '0;
    else                     r_phase <= r_phase + 1'b1;
  end

  assign o_phase  = r_phase;
  assign o_at_end = (r_phase == PH_END);

endmodule

// File: rtl/vg_strobe_ctrl.sv
// Strobe controller: one-cycle state/AVG enables on a programmable phase
// divider, stretched by memory wait states, gated by halt and single-step.
module vg_strobe_ctrl
  import vg_pkg::*;
#(
  parameter int DIV     = VG_DIV_DEF,
  parameter int PH_W    = $clog2(DIV),
  parameter int WAIT_W  = VG_WAIT_W_DEF,
  parameter int STALL_W = VG_STALL_W_DEF
) (
  input  logic               clk_12MHz,
  input  logic               reset_not,
  input  logic               vg_go,
  input  logic               halt,
  input  logic               mem_access,
  input  logic               mem_ready,
  input  logic [WAIT_W-1:0]  wait_cfg,
  input  logic               step_mode,
  input  logic               step,
  output logic               state_stb,
  output logic               avg_stb,
  output logic [PH_W-1:0]    phase,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);

  vg_state_e          r_state;
  logic               r_stb;
  logic               r_avg;
  logic               r_busy;
  logic               r_step;
  logic               r_halt_pend;
  logic [WAIT_W-1:0]  r_wait;
  logic [STALL_W-1:0] r_stall;

  logic               w_adv;
  logic               w_to_wait;
  logic               w_ph_clr;
  logic               w_ph_hold;
  logic               w_at_end;
  logic [PH_W-1:0]    w_phase;

  vg_phase_div #(
    .DIV  (DIV),
    .PH_W (PH_W)
  ) u_div (
    .clk_12MHz (clk_12MHz),
    .reset_not (reset_not),
    .i_clr     (w_ph_clr),
    .i_hold    (w_ph_hold),
    .o_phase   (w_phase),
    .o_at_end  (w_at_end)
  );

  // Advance decision and phase control for the current cycle. An advance
  // always restarts the phase at 0 so the strobe cycle is phase 0.
  always_comb begin
    w_adv     = 1'b0;
    w_to_wait = 1'b0;
    w_ph_clr  = 1'b0;
    w_ph_hold = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: w_ph_clr = 1'b1;
      ST_RUN: begin
        if (r_halt_pend) begin
          // Strobe cycle of a halting advance: park phase at 0 for HALT.
          w_ph_clr = 1'b1;
        end else if (w_at_end) begin
          if (mem_access && !mem_ready) begin
            w_to_wait = 1'b1;
            w_ph_hold = 1'b1;
          end else if (step_mode && !r_step) begin
            w_ph_hold = 1'b1;
          end else begin
            w_adv    = 1'b1;
            w_ph_clr = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Leaving WAIT is a completed memory access; it advances directly.
        if (mem_ready && (r_wait == '0)) begin
          w_adv    = 1'b1;
          w_ph_clr = 1'b1;
        end else begin
          w_ph_hold = 1'b1;
        end
      end
      default: w_ph_clr = 1'b1;
    endcase
  end

  // Main FSM with registered strobes, busy, wait countdown, step latch and
  // saturating stall counter. A halting advance keeps RUN for the strobe
  // cycle and drops into HALT on the following edge.
  always_ff @(posedge clk_12MHz or negedge reset_not) begin
    if (!reset_not) begin
      r_state     <= ST_IDLE;
      r_stb       <= 1'b0;
      r_avg       <= 1'b0;
      r_busy      <= 1'b0;
      r_step      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_wait      <= '0;
      r_stall     <= '0;
    end else begin
      r_stb       <= w_adv;
      r_avg       <= w_adv && !halt;
      r_halt_pend <= w_adv && halt;
      if (w_adv)     r_step <= 1'b0;
      else if (step) r_step <= 1'b1;
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (vg_go) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_stall <= '0;
          end
        end
        ST_RUN: begin
          if (r_halt_pend) begin
            r_state <= ST_HALT;
            r_busy  <= 1'b0;
          end else if (w_to_wait) begin
            r_state <= ST_WAIT;
            r_wait  <= wait_cfg;
          end
        end
        ST_WAIT: begin
          if (r_stall != '1) r_stall <= r_stall + 1'b1;
          if (w_adv)          r_state <= ST_RUN;
          else if (mem_ready) r_wait  <= r_wait - 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_stb = r_stb;
  assign avg_stb   = r_avg;
  assign phase     = w_phase;
  assign busy      = r_busy;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_vg_strobe_ctrl.sv
// Directed bench for vg_strobe_ctrl (DIV=4, WAIT_W=4, STALL_W=4).
module tb_vg_strobe_ctrl;

  logic       clk_12MHz;
  logic       reset_not;
  logic       vg_go, halt, mem_access, mem_ready, step_mode, step;
  logic [3:0] wait_cfg;
  logic       state_stb, avg_stb, busy;
  logic [1:0] phase;
  logic [3:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  int nstb;

  vg_strobe_ctrl #(
    .DIV     (4),
    .WAIT_W  (4),
    .STALL_W (4)
  ) dut (
    .clk_12MHz  (clk_12MHz),
    .reset_not  (reset_not),
    .vg_go      (vg_go),
    .halt       (halt),
    .mem_access (mem_access),
    .mem_ready  (mem_ready),
    .wait_cfg   (wait_cfg),
    .step_mode  (step_mode),
    .step       (step),
    .state_stb  (state_stb),
    .avg_stb    (avg_stb),
    .phase      (phase),
    .busy       (busy),
    .stall_cnt  (stall_cnt)
  );

  initial clk_12MHz = 1'b0;
  always #5 clk_12MHz = ~clk_12MHz;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1ns so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk_12MHz);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go();
    vg_go = 1'b1;
    tick();
    vg_go = 1'b0;
  endtask

  initial begin
    reset_not = 1'b0; vg_go = 0; halt = 0; mem_access = 0; mem_ready = 1;
    step_mode = 0; step = 0; wait_cfg = 4'd0;
    #12;
    chk("rst_stb", state_stb, 0);
    chk("rst_avg", avg_stb, 0);
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_cnt, 0);
    #10 reset_not = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Free run: strobes on edges 4 and 8 after go, phase 0,1,2,3,0.
    go();
    chk("go_phase", phase, 0);
    chk("go_busy", busy, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("run_phase", phase, i % 4);
      chk("run_stb", state_stb, (i % 4 == 0) ? 1 : 0);
      chk("run_avg", avg_stb, (i % 4 == 0) ? 1 : 0);
    end

    // Memory wait: ready low over the advance point plus 4 WAIT edges, wait_cfg=2.
    wait_cfg = 4'd2; mem_access = 1; mem_ready = 0;
    ticks(3);
    chk("pre_wait_phase", phase, 3);
    tick();
    chk("wait_enter_stb", state_stb, 0);
    chk("wait_enter_phase", phase, 3);
    ticks(4);
    chk("wait_hold_phase", phase, 3);
    chk("wait_stall4", stall_cnt, 4);
    chk("wait_busy", busy, 1);
    mem_ready = 1;
    ticks(2);
    chk("wait_cd_stb", state_stb, 0);
    chk("wait_cd_stall", stall_cnt, 6);
    tick();
    chk("wait_exit_stb", state_stb, 1);
    chk("wait_exit_avg", avg_stb, 1);
    chk("wait_exit_phase", phase, 0);
    chk("wait_stall7", stall_cnt, 7);
    mem_access = 0;

    // Halt before next advance: final strobe without avg, then HALT.
    ticks(3);
    halt = 1;
    tick();
    chk("halt_stb", state_stb, 1);
    chk("halt_avg", avg_stb, 0);
    chk("halt_stb_busy", busy, 1);
    tick();
    chk("halt_busy", busy, 0);
    chk("halt_stb_off", state_stb, 0);
    nstb = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nstb += state_stb;
      chk("halt_phase", phase, 0);
    end
    chk("halt_nostb", nstb, 0);
    // Restart while halt still high: one strobe, then back to HALT.
    go();
    chk("rego_busy", busy, 1);
    ticks(3);
    chk("rego_pre_stb", state_stb, 0);
    tick();
    chk("rego_stb", state_stb, 1);
    chk("rego_avg", avg_stb, 0);
    tick();
    chk("rehalt_busy", busy, 0);
    halt = 0;
    go();
    ticks(3);
    chk("resume_pre", state_stb, 0);
    tick();
    chk("resume_stb", state_stb, 1);
    chk("resume_avg", avg_stb, 1);

    // Single-step: hold at phase 3 until a latched step is consumed.
    step_mode = 1;
    ticks(6);
    chk("step_hold_phase", phase, 3);
    chk("step_hold_stb", state_stb, 0);
    step = 1;
    tick();
    step = 0;
    chk("step_latch_stb", state_stb, 0);
    tick();
    chk("step1_stb", state_stb, 1);
    chk("step1_phase", phase, 0);
    // Double step before consumption yields a single strobe.
    step = 1; tick(); tick(); step = 0;
    nstb = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      nstb += state_stb;
    end
    chk("dbl_step_stbs", nstb, 1);
    chk("dbl_step_phase", phase, 3);
    // Dropping step_mode while parked advances on the next edge.
    step_mode = 0;
    tick();
    chk("stepoff_stb", state_stb, 1);

    // Asynchronous reset in the middle of WAIT.
    mem_access = 1; mem_ready = 0;
    ticks(5);
    chk("pre_rst_stall", stall_cnt, 1);
    #3 reset_not = 1'b0;
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_busy", busy, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_stb", state_stb, 0);
    #1 reset_not = 1'b1;
    mem_access = 0; mem_ready = 1;
    nstb = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      nstb += state_stb + busy;
    end
    chk("post_rst_quiet", nstb, 0);

    // Stall counter saturation, then wait_cfg=0 exits on first ready.
    go();
    mem_access = 1; mem_ready = 0; wait_cfg = 4'd0;
    ticks(4);
    ticks(20);
    chk("sat_stall", stall_cnt, 15);
    chk("sat_phase", phase, 3);
    mem_ready = 1;
    tick();
    chk("sat_exit_stb", state_stb, 1);
    chk("sat_exit_stall", stall_cnt, 15);
    tick();
    chk("no_back2back", state_stb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vg_strobe_ctrl.md
Name: vg_strobe_ctrl

Overview:
Parametrised successor to the vector-generator clock/strobe controller. It runs in a single clock domain on clk_12MHz. It produces one-cycle enable strobes (state_stb, avg_stb) instead of derived clocks. The strobe period is a programmable phase divider, with stretching for vector-memory wait states, halt gating and single-step. It sits between the VG state machine, the AVG datapath and the vector-memory arbiter.

Parameters:
DIV, 4, clk_12MHz cycles per state cycle (4 gives a 3 MHz state rate); must be >= 2.
PH_W, $clog2(DIV), phase counter width.
WAIT_W, 4, width of the programmable extra memory wait count.
STALL_W, 16, width of the debug stall counter.

Ports:
clk_12MHz  in  1  sole clock.
reset_not  in  1  asynchronous, active-low reset.
vg_go  in  1  one-cycle start pulse from the CPU decode.
halt  in  1  level; the VG state machine is in HALT.
mem_access  in  1  level; the current VG state needs a vector-memory read.
mem_ready  in  1  level; arbiter grant / data valid.
wait_cfg  in  WAIT_W  extra wait cycles inserted after every memory stall.
step_mode  in  1  level; single-step enable.
step  in  1  one-cycle step request pulse.
state_stb  out  1  one-cycle enable to advance the VG state machine.
avg_stb  out  1  one-cycle enable to the AVG datapath.
phase  out  PH_W  current phase, 0..DIV-1.
busy  out  1  high in RUN or WAIT.
stall_cnt  out  STALL_W  saturating count of WAIT cycles.

Behaviour:
- Reset (reset_not low, asynchronous): state=IDLE, phase=0, state_stb=0, avg_stb=0, busy=0, stall_cnt=0, wait counter=0, step latch=0.
- States: IDLE, RUN, WAIT, HALT. All outputs are registered.
- IDLE: phase held at 0. vg_go -> RUN, phase=0, stall_cnt cleared.
- RUN: phase increments every cycle and wraps DIV-1 -> 0. Advance point is phase==DIV-1. At the advance point:
  - mem_access=1 and mem_ready=0 -> WAIT. Wait counter loads wait_cfg, no strobe, phase holds at DIV-1.
  - step_mode=1 and no step latched -> phase holds at DIV-1, no strobe. State stays RUN.
  - Otherwise, state_stb is set on that edge, so it is high exactly during the next cycle, when phase==0. The step latch clears.
- WAIT: phase holds at DIV-1. stall_cnt increments each cycle and saturates at all-ones.
  - While mem_ready=0, the wait counter holds.
  - Once mem_ready=1, the wait counter decrements each cycle. When it is 0 with mem_ready=1, the controller advances exactly as in RUN: strobe, then RUN.
  - mem_ready dropping mid-countdown freezes the counter.
  - wait_cfg=0 gives a strobe on the first cycle mem_ready is seen.
- avg_stb = state_stb AND NOT halt, with halt sampled on the same edge that sets state_stb.
- HALT entry: a strobe issued while halt=1 moves the FSM to HALT after that strobe. That final state_stb still fires; avg_stb is suppressed.
- HALT: phase=0, busy=0, no strobes. vg_go -> RUN, phase=0. If halt is still high at the next advance point, one state_stb fires, then the FSM re-enters HALT.
- vg_go in RUN or WAIT is ignored.
- step: latched on any cycle, held until consumed by an advance. A second step before consumption is dropped.
- step_mode deasserted while holding at DIV-1: the advance occurs on the next cycle.
- A strobe never occurs on two consecutive cycles. Minimum strobe spacing is DIV cycles.

Decomposition:
- Package vg_pkg: state encoding constants (IDLE=0, RUN=1, WAIT=2, HALT=3) and the default DIV/WAIT_W localparams.
- One sub-module, vg_phase_div: phase counter with clear, hold and wrap, and an at_end flag. The FSM, wait counter, step latch and stall counter live in vg_strobe_ctrl.

Test Plan:
- DIV=4, vg_go, mem_access=0, halt=0 -> state_stb and avg_stb high on cycles 4, 8, 12… after go; phase sequence 0,1,2,3,0; busy=1.
- mem_access=1, mem_ready low for 5 cycles then high, wait_cfg=2 -> phase holds at 3; strobe 3 cycles after mem_ready rises; stall_cnt=7.
- halt=1 before the 2nd advance -> state_stb fires with avg_stb=0; next cycle state=HALT, busy=0, no further strobes. vg_go -> strobes resume 4 cycles later.
- step_mode=1, step pulses at cycles 10 and 30 -> exactly two strobes, each one cycle after phase first reaches 3 following the pulse. A double step before consumption -> one strobe.
- reset_not low mid-WAIT (asynchronous, between edges) -> all outputs 0 and phase=0 immediately. After release, no strobe until vg_go.
- stall_cnt saturation with STALL_W=4 and mem_ready held low for 20 cycles -> stall_cnt sticks at 15.
